// File: rtl/adder_subtractor_pkg.sv
// adder_subtractor_pkg
//   Shared definitions for the serial adder/subtractor datapaths and their
//   control FSMs: the control-state encoding and its enum type.
package adder_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } serial_state_e;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// fs_cell
//   Combinational 1-bit full subtractor: x - y - bin.
//   Ports:
//     x    in   minuend bit
//     y    in   subtrahend bit
//     bin  in   borrow in
//     d    out  difference bit
//     bout out  borrow out
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one
//   full-subtractor cell evaluated per clock, with a start/done handshake.
//   Optional signed-overflow flag when SUB_OVF_FLAG_EN is defined.
//   Ports:
//     clk        in   clock, all logic on posedge
//     rst_n      in   synchronous active-low reset
//     start      in   operation request, sampled only in IDLE
//     a, b       in   WIDTH-bit minuend / subtrahend, captured on accepted start
//     busy       out  high in RUN and DONE
//     done       out  one-cycle pulse when diff/borrow_out are updated
//     diff       out  a - b mod 2^WIDTH, held until the next result
//     borrow_out out  final borrow (unsigned a < b)
//     ovf        out  signed overflow (SUB_OVF_FLAG_EN only)
//
//   state | meaning
//   ------+------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one bit per cycle through fs_cell, count = bit index
//   DONE  | done pulse; result registers freshly written
module serial_subtractor
    import adder_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Only WIDTH-1 result bits need storing: the last bit goes straight to diff.
    logic [WIDTH-2:0] r_sr_q, r_sr_d;
    logic             bflop_q, bflop_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_d, cell_bout;
    logic [WIDTH-1:0] r_shift;

    fs_cell u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (bflop_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign r_shift = {cell_d, r_sr_q};

`ifdef SUB_OVF_FLAG_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        r_sr_d   = r_sr_q;
        bflop_d  = bflop_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SUB_OVF_FLAG_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    bflop_d = 1'b0;
                    count_d = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
`ifdef SUB_OVF_FLAG_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                r_sr_d  = r_shift[WIDTH-1:1];
                bflop_d = cell_bout;
                if (count_q == LAST) begin
                    diff_d   = r_shift;
                    borrow_d = cell_bout;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
`ifdef SUB_OVF_FLAG_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_sr_q   <= '0;
            bflop_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            r_sr_q   <= r_sr_d;
            bflop_q  <= bflop_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SUB_OVF_FLAG_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf        = ovf_q;
`endif

endmodule
